// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execute-stage FSM states.
// The ALU decoder imports the same package, so both sides agree on the codes.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b110;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Request/result bundle between decode, the execute stage and writeback.
// master = upstream/downstream driver side, slave = the execute stage.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );
endinterface

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle logical shifter: working register plus shift-amount down-counter.
// done is high during the cycle whose edge applies the final bit; value is that shifted word.
module alu_iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               left,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [WIDTH-1:0]   value
);

  localparam logic [SHAMT_W-1:0] ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   work_p1;
  logic [SHAMT_W-1:0] count_p1;
  logic               left_p1;

  assign value = left_p1 ? {work_p1[WIDTH-2:0], 1'b0} : {1'b0, work_p1[WIDTH-1:1]};
  assign done  = (count_p1 == ONE);

  // Control: clearing the count on reset is what discards an in-flight shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p1 <= '0;
      left_p1  <= 1'b0;
    end else if (start) begin
      count_p1 <= shamt;
      left_p1  <= left;
    end else if (count_p1 != '0) begin
      count_p1 <= count_p1 - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      work_p1 <= operand;
    end else if (count_p1 != '0) begin
      work_p1 <= value;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready output register.
// Define ALU_EXEC_SHIFT_EN to enable iterative SLL/SRL; otherwise those codes are illegal.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus
);

  state_t           state, state_next;
  logic             accept, pop, start_shift, shift_done, load_single;
  logic [WIDTH-1:0] alu_res_p0;
  logic             illegal_p0;
  logic             shift_req_p0;

  logic [WIDTH-1:0] result_p1;
  logic             zero_p1, illegal_p1, vld_p1;

  logic signed [WIDTH-1:0] a_s, b_s;

  assign pop          = vld_p1 && bus.out_ready;
  assign bus.in_ready = (state == S_IDLE) && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign a_s          = bus.src_a;
  assign b_s          = bus.src_b;

  // Stage p0: combinational decode/compute of the presented operation.
  always_comb begin
    alu_res_p0   = '0;
    illegal_p0   = 1'b0;
    shift_req_p0 = 1'b0;
    case (bus.alu_control)
      ALU_ADD: alu_res_p0 = bus.src_a + bus.src_b;
      ALU_SUB: alu_res_p0 = bus.src_a - bus.src_b;
      ALU_OR:  alu_res_p0 = bus.src_a | bus.src_b;
      ALU_AND: alu_res_p0 = bus.src_a & bus.src_b;
      ALU_SLT: alu_res_p0 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
`ifdef ALU_EXEC_SHIFT_EN
      // A zero shift amount completes immediately with src_a unchanged.
      ALU_SLL, ALU_SRL: begin
        alu_res_p0   = bus.src_a;
        shift_req_p0 = (bus.src_b[SHAMT_W-1:0] != '0);
      end
`endif
      default: illegal_p0 = 1'b1;
    endcase
  end

  assign start_shift = accept && shift_req_p0;
  assign load_single = accept && !shift_req_p0;

`ifdef ALU_EXEC_SHIFT_EN
  logic [WIDTH-1:0] shift_res;

  alu_iter_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (start_shift),
    .left    (bus.alu_control == ALU_SLL),
    .operand (bus.src_a),
    .shamt   (bus.src_b[SHAMT_W-1:0]),
    .done    (shift_done),
    .value   (shift_res)
  );

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    case (state)
      S_IDLE:  if (start_shift) state_next = S_SHIFT;
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (shift_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end
`else
  assign shift_done = 1'b0;
  assign bus.busy   = 1'b0;

  always_comb begin
    state_next = S_IDLE;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Stage p1: output register. In SHIFT no new op is accepted, so the shift
  // completion and a single-cycle load never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      result_p1  <= '0;
      zero_p1    <= 1'b1;
      illegal_p1 <= 1'b0;
    end else if (shift_done) begin
`ifdef ALU_EXEC_SHIFT_EN
      vld_p1     <= 1'b1;
      result_p1  <= shift_res;
      zero_p1    <= (shift_res == '0);
      illegal_p1 <= 1'b0;
`endif
    end else if (load_single) begin
      vld_p1     <= 1'b1;
      result_p1  <= alu_res_p0;
      zero_p1    <= (alu_res_p0 == '0);
      illegal_p1 <= illegal_p0;
    end else if (pop) begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.result    = result_p1;
  assign bus.zero      = zero_p1;
  assign bus.illegal   = illegal_p1;

endmodule
